// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  // Operand width used when the parent does not override WIDTH.
  localparam int unsigned DefaultWidth = 4;

  // Control FSM states: waiting for operands, bit-serial processing, result held.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } addsub_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used once per cycle by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Purely combinational sum and carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor: one bit pair per cycle, LSB first, with a
// valid/ready handshake on both operand and result sides.
module serial_adder_subtractor
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  addsub_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  // Carry into the MSB, kept for the signed-overflow flag.
  logic             cmsb_q, cmsb_d;

  logic fa_s;
  logic fa_cout;

  full_adder u_full_adder (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if (cnt_q == LastCnt) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; result fields are forced to zero outside DONE.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    S         = '0;
    Cout      = 1'b0;
    V         = 1'b0;
    if (state_q == StDone) begin
      S    = s_q;
      Cout = carry_q;
      V    = cmsb_q ^ carry_q;
    end
  end

  // Datapath next-state: load on accept, shift one bit per SHIFT cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    if (state_q == StIdle && in_valid) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with ctrl.
      a_d     = A;
      b_d     = B ^ {WIDTH{ctrl}};
      carry_d = ctrl;
      cnt_d   = '0;
      s_d     = '0;
      cmsb_d  = 1'b0;
    end else if (state_q == StShift) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      s_d     = {fa_s, s_q[WIDTH-1:1]};
      carry_d = fa_cout;
      cnt_d   = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) begin
        cmsb_d = carry_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
    end
  end

endmodule
